mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_multicycle_control.sv | 202 ++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback. It also keeps a count of retired
// instructions and a sticky flag for undecoded opcodes.
module mips_multicycle_control #(
  parameter int RETIRE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              OP,
  input  logic                    Zero,
  input  logic                    MemReady,
  output logic                    PCEnable,
  output logic                    IorD,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    IRWrite,
  output logic                    ALUSrcA,
  output logic                    ZeroExt,
  output logic                    RegWrite,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              PCSource,
  output logic [1:0]              WriteRegSel,
  output logic [1:0]              MemtoReg,
  output logic [2:0]              ALUOp,
  output logic [3:0]              State,
  output logic [RETIRE_WIDTH-1:0] Retired,
  output logic                    IllegalOp
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;
  localparam logic [2:0] ALU_RT  = 3'b111;

  state_t state;
  state_t next_state;
  logic   retire;
  logic   illegal_dec;

  // Immediate-class ALU operation and extension mode: {ZeroExt, ALUOp}.
  // The IR stays stable through IEXEC and IWB, so both states share this.
  function automatic logic [3:0] imm_ctrl(input logic [5:0] op);
    case (op)
      6'b001100: imm_ctrl = {1'b1, ALU_AND};
      6'b001101: imm_ctrl = {1'b1, ALU_OR};
      6'b001111: imm_ctrl = {1'b1, ALU_LUI};
      default:   imm_ctrl = {1'b0, ALU_ADD};
    endcase
  endfunction

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Next-state logic plus the retire and illegal-opcode events.
  always_comb begin
    next_state  = FETCH;
    retire      = 1'b0;
    illegal_dec = 1'b0;
    case (state)
      FETCH:  next_state = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (OP)
          6'b000000:                                  next_state = RTEXEC;
          6'b100011, 6'b101011:                       next_state = MEMADR;
          6'b000100, 6'b000101:                       next_state = BRANCH;
          6'b000010, 6'b000011:                       next_state = JUMP;
          6'b001000, 6'b001100, 6'b001101, 6'b001111: next_state = IEXEC;
          default: begin
            next_state  = FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      MEMADR: next_state = (OP == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:  next_state = MemReady ? MEMWB : MEMRD;
      MEMWB:  begin next_state = FETCH; retire = 1'b1; end
      MEMWR:  begin
        next_state = MemReady ? FETCH : MEMWR;
        retire     = MemReady;
      end
      RTEXEC: next_state = RTWB;
      RTWB:   begin next_state = FETCH; retire = 1'b1; end
      BRANCH: begin next_state = FETCH; retire = 1'b1; end
      JUMP:   begin next_state = FETCH; retire = 1'b1; end
      IEXEC:  next_state = IWB;
      IWB:    begin next_state = FETCH; retire = 1'b1; end
      default: next_state = FETCH;
    endcase
  end

  // Moore output decode; PCEnable and the FETCH IRWrite also follow inputs.
  always_comb begin
    PCEnable    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    ZeroExt     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    WriteRegSel = 2'b00;
    MemtoReg    = 2'b00;
    ALUOp       = ALU_ADD;
    case (state)
      FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = MemReady;
        PCEnable = MemReady;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_RT;
      end
      RTWB: begin
        RegWrite    = 1'b1;
        WriteRegSel = 2'b01;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        // BEQ (OP[0]=0) takes on Zero, BNE (OP[0]=1) on not Zero.
        PCEnable = Zero ^ OP[0];
      end
      JUMP: begin
        PCSource = 2'b10;
        PCEnable = 1'b1;
        if (OP[0]) begin
          // JAL links the PC+4 already latched during FETCH.
          RegWrite    = 1'b1;
          WriteRegSel = 2'b10;
          MemtoReg    = 2'b10;
        end
      end
      IEXEC: begin
        ALUSrcA            = 1'b1;
        ALUSrcB            = 2'b10;
        {ZeroExt, ALUOp}   = imm_ctrl(OP);
      end
      IWB: begin
        RegWrite           = 1'b1;
        {ZeroExt, ALUOp}   = imm_ctrl(OP);
      end
      default: ;
    endcase
  end

  assign State = state;

  // Retired-instruction counter; wraps naturally at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       Retired <= '0;
    else if (retire) Retired <= Retired + RETIRE_WIDTH'(1);
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            IllegalOp <= 1'b0;
    else if (illegal_dec) IllegalOp <= 1'b1;
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: table of instructions with expected
// state sequences and writeback/branch controls, plus hand sequences for
// memory stalls, illegal opcodes, counter wrap and reset mid-instruction.
module tb_mips_multicycle_control;

  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    OP;
  logic          Zero;
  logic          MemReady;
  logic          PCEnable, IorD, MemRead, MemWrite, IRWrite;
  logic          ALUSrcA, ZeroExt, RegWrite;
  logic [1:0]    ALUSrcB, PCSource, WriteRegSel, MemtoReg;
  logic [2:0]    ALUOp;
  logic [3:0]    State;
  logic [RW-1:0] Retired;
  logic          IllegalOp;

  mips_multicycle_control #(.RETIRE_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
    .PCEnable(PCEnable), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ZeroExt(ZeroExt),
    .RegWrite(RegWrite), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .WriteRegSel(WriteRegSel), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
    .State(State), .Retired(Retired), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        zero;
    int          n;
    logic [39:0] seq;
    logic        rw;
    logic [1:0]  wsel;
    logic [1:0]  mtr;
    logic        pcen;
    logic [1:0]  pcsrc;
    logic        mw;
    logic [2:0]  aluop;
    logic        ze;
  } vec_t;

  vec_t       tbl[13];
  logic [3:0] sb_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [RW-1:0] ret_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one instruction; expected states go into the scoreboard up front
  // and are popped one per cycle. Returns while still in the last state.
  task automatic run_instr(input logic [5:0] op, input logic zero, input int n,
                           input logic [39:0] seq, input logic [9:0] mr);
    OP   = op;
    Zero = zero;
    for (int k = 0; k < n; k++) sb_q.push_back(seq[4*k +: 4]);
    for (int k = 0; k < n; k++) begin
      logic [3:0] exp_s;
      MemReady = mr[k];
      #1;
      exp_s = sb_q.pop_front();
      check($sformatf("state op=%b cyc%0d", op, k), {28'b0, State}, {28'b0, exp_s});
      if (k < n - 1) next_cycle();
    end
  endtask

  initial begin
    tbl[0]  = '{"rtype", 6'b000000, 1'b0, 4, 40'h7610,  1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0};
    tbl[1]  = '{"lw",    6'b100011, 1'b0, 5, 40'h43210, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0};
    tbl[2]  = '{"sw",    6'b101011, 1'b0, 4, 40'h5210,  1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0};
    tbl[3]  = '{"beq_t", 6'b000100, 1'b1, 3, 40'h810,   1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 3'b001, 1'b0};
    tbl[4]  = '{"beq_n", 6'b000100, 1'b0, 3, 40'h810,   1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 3'b001, 1'b0};
    tbl[5]  = '{"bne_n", 6'b000101, 1'b1, 3, 40'h810,   1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 3'b001, 1'b0};
    tbl[6]  = '{"bne_t", 6'b000101, 1'b0, 3, 40'h810,   1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 3'b001, 1'b0};
    tbl[7]  = '{"j",     6'b000010, 1'b0, 3, 40'h910,   1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 3'b000, 1'b0};
    tbl[8]  = '{"jal",   6'b000011, 1'b0, 3, 40'h910,   1'b1, 2'b10, 2'b10, 1'b1, 2'b10, 1'b0, 3'b000, 1'b0};
    tbl[9]  = '{"addi",  6'b001000, 1'b0, 4, 40'hBA10,  1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0};
    tbl[10] = '{"andi",  6'b001100, 1'b0, 4, 40'hBA10,  1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b011, 1'b1};
    tbl[11] = '{"ori",   6'b001101, 1'b0, 4, 40'hBA10,  1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b010, 1'b1};
    tbl[12] = '{"lui",   6'b001111, 1'b0, 4, 40'hBA10,  1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b100, 1'b1};

    // Asynchronous reset with no clock edge yet.
    reset = 1'b1; OP = 6'b0; Zero = 1'b0; MemReady = 1'b1;
    #2;
    check("reset state",     {28'b0, State}, 32'd0);
    check("reset retired",   {29'b0, Retired}, 32'd0);
    check("reset illegal",   {31'b0, IllegalOp}, 32'd0);
    check("reset fetch dec", {28'b0, MemRead, IorD, ALUSrcB}, {28'b0, 4'b1001});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ret_model = '0;

    // R-type right after reset, with RegWrite only in RTWB.
    run_instr(6'b000000, 1'b0, 4, 40'h7610, 10'h3FF);
    check("rtwb regwrite/wsel", {29'b0, RegWrite, WriteRegSel}, {29'b0, 3'b101});
    next_cycle();
    ret_model++;
    check("retired after rtype", {29'b0, Retired}, {29'b0, ret_model});

    // Table of single instructions with MemReady held high.
    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].zero, tbl[i].n, tbl[i].seq, 10'h3FF);
      check({tbl[i].name, " ctrl"},
            {19'b0, RegWrite, WriteRegSel, MemtoReg, PCEnable, PCSource, MemWrite, ALUOp, ZeroExt},
            {19'b0, tbl[i].rw, tbl[i].wsel, tbl[i].mtr, tbl[i].pcen, tbl[i].pcsrc,
             tbl[i].mw, tbl[i].aluop, tbl[i].ze});
      next_cycle();
      ret_model++;
      check({tbl[i].name, " retired"}, {29'b0, Retired}, {29'b0, ret_model});
    end

    // LW with three MemReady=0 cycles in MEMRD: 8 cycles total.
    run_instr(6'b100011, 1'b0, 8, 40'h43333210, 10'h0C7);
    check("lw stall memtoreg", {30'b0, MemtoReg}, 32'd1);
    next_cycle();
    ret_model++;
    check("lw stall retired", {29'b0, Retired}, {29'b0, ret_model});

    // FETCH stall: no IR/PC load until MemReady.
    OP = 6'b000000; MemReady = 1'b0;
    #1;
    check("fetch stall irwrite/pcen", {30'b0, IRWrite, PCEnable}, 32'd0);
    next_cycle();
    check("fetch stall hold", {28'b0, State}, 32'd0);
    MemReady = 1'b1;
    #1;
    check("fetch ready irwrite/pcen", {30'b0, IRWrite, PCEnable}, 32'd3);
    run_instr(6'b000000, 1'b0, 4, 40'h7610, 10'h3FF);
    next_cycle();
    ret_model++;
    check("fetch stall retired", {29'b0, Retired}, {29'b0, ret_model});

    // Illegal opcode: back to FETCH, flag sticks, no retire.
    run_instr(6'b111111, 1'b0, 2, 40'h10, 10'h3FF);
    next_cycle();
    check("illegal state", {28'b0, State}, 32'd0);
    check("illegal flag", {31'b0, IllegalOp}, 32'd1);
    check("illegal retired", {29'b0, Retired}, {29'b0, ret_model});
    run_instr(6'b001000, 1'b0, 4, 40'hBA10, 10'h3FF);
    next_cycle();
    ret_model++;
    check("illegal sticky", {31'b0, IllegalOp}, 32'd1);
    check("post-illegal retired", {29'b0, Retired}, {29'b0, ret_model});

    // Reset while stalled in MEMWR.
    run_instr(6'b101011, 1'b0, 4, 40'h5210, 10'h007);
    check("memwr before reset", {31'b0, MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset memwrite", {30'b0, MemWrite, RegWrite}, 32'd0);
    check("reset mid state", {28'b0, State}, 32'd0);
    check("reset clears illegal", {31'b0, IllegalOp}, 32'd0);
    check("reset clears retired", {29'b0, Retired}, 32'd0);
    next_cycle();
    check("reset held state", {28'b0, State}, 32'd0);
    reset = 1'b0;
    ret_model = '0;
    run_instr(6'b000000, 1'b0, 4, 40'h7610, 10'h3FF);
    next_cycle();
    ret_model++;
    check("after reset retired", {29'b0, Retired}, {29'b0, ret_model});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
